// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port, variable-latency memory between the
// instruction-fetch (IF) stage and the load/store (MEM) stage.
//  - IDLE/FETCH/DATA FSM serialises accesses, with at least one IDLE cycle between them.
//  - Data has priority. After STARVE_MAX consecutive data grants while fetch waits,
//    the next grant goes to fetch.
//  - if_stall holds the IF stage until its fetch completes.
// Ports:
//  clk, rst                 clock (rising edge), async active-high reset
//  if_ce/if_addr            fetch request and address (held while if_stall)
//  if_rdata/if_stall        fetched word (valid when if_stall drops), IF stall
//  d_req/d_we/d_addr/...    data request and fields (held until d_ack)
//  d_rdata/d_ack            load data and one-cycle completion pulse
//  mem_*                    memory port: request held until mem_ready
module imem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_ce,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_stall,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   starve_cnt;
  logic            starved;
  logic            grant_fetch;
  logic            grant_data;
  logic            fetch_done;
  logic [DW-1:0]   if_rdata_q;
  logic [DW-1:0]   d_rdata_q;

  assign starved    = if_ce && (starve_cnt == CW'(STARVE_MAX));
  assign fetch_done = (state == FETCH) && mem_ready;
  assign d_ack      = (state == DATA) && mem_ready;
  assign if_stall   = if_ce && !fetch_done;

  // Read data bypasses the holding register in the completion cycle, so the
  // consumer sees it in the same cycle its stall drops or its ack fires.
  assign if_rdata = fetch_done ? mem_rdata : if_rdata_q;
  assign d_rdata  = d_ack ? mem_rdata : d_rdata_q;

  always_comb begin
    state_d     = state;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !starved) begin
          state_d    = DATA;
          grant_data = 1'b1;
        end else if (if_ce) begin
          state_d     = FETCH;
          grant_fetch = 1'b1;
        end
      end
      FETCH, DATA: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Saturating count of data grants made while fetch was waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_data && if_ce) begin
      if (starve_cnt != CW'(STARVE_MAX)) starve_cnt <= starve_cnt + CW'(1);
    end else if (grant_fetch) begin
      starve_cnt <= '0;
    end else if ((state == IDLE) && !if_ce) begin
      starve_cnt <= '0;
    end
  end

  // Memory port fields are captured on the grant edge and held until mem_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (grant_data) begin
      mem_req   <= 1'b1;
      mem_we    <= d_we;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      mem_wstrb <= d_we ? d_wstrb : '0;
    end else if (grant_fetch) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (mem_ready && (state != IDLE)) begin
      mem_req <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (fetch_done) if_rdata_q <= mem_rdata;
      if (d_ack)      d_rdata_q  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter. Expected memory grants are queued as
// stimulus is set up, and each one is popped and compared when the DUT raises mem_req.
// The bench also acts as the memory, answering each grant after a chosen latency.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          fetch;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  imem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_ce(if_ce), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Protocol guard: once presented, d_req must stay high until d_ack.
  logic d_pend = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      d_pend <= 1'b0;
    end else begin
      if (d_pend && !d_req) begin
        errors++;
        $error("FAIL d_req_hold: d_req observed 0 expected 1 before d_ack");
      end
      d_pend <= d_req && !d_ack;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_f(input logic [31:0] a);
    exp_t e;
    e.fetch = 1'b1; e.addr = a; e.we = 1'b0; e.wstrb = 4'b0000; e.wdata = '0;
    sb.push_back(e);
  endtask

  task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws);
    exp_t e;
    e.fetch = 1'b0; e.addr = a; e.we = we; e.wstrb = ws; e.wdata = wd;
    sb.push_back(e);
  endtask

  // Wait (bounded) for the next grant, compare it with the scoreboard head,
  // then complete it: mem_ready goes high lat cycles after the first mem_req cycle.
  task automatic serve(input int max_wait, input int lat, input logic [31:0] rd,
                       input bit keep_d, input bit keep_if);
    exp_t e;
    int   n;
    n = 0;
    while (mem_req !== 1'b1 && n < max_wait) begin
      step();
      n++;
    end
    chk("grant_seen", {31'd0, mem_req}, 32'd1);
    if (sb.size() == 0) begin
      $display("FAIL scoreboard: observed empty expected entry");
      $fatal(1, "scoreboard empty");
    end
    e = sb.pop_front();
    chk(e.fetch ? "fetch_addr" : "data_addr", mem_addr, e.addr);
    chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
    chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e.wstrb});
    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
    chk("if_stall_wait", {31'd0, if_stall}, {31'd0, if_ce});
    chk("d_ack_early", {31'd0, d_ack}, 32'd0);
    for (int i = 1; i < lat; i++) begin
      step();
      chk("mem_req_hold", {31'd0, mem_req}, 32'd1);
      chk("mem_addr_hold", mem_addr, e.addr);
      chk("if_stall_wait", {31'd0, if_stall}, {31'd0, if_ce});
    end
    step();
    mem_ready = 1'b1;
    mem_rdata = rd;
    #1;
    chk("mem_req_ready", {31'd0, mem_req}, 32'd1);
    if (e.fetch) begin
      chk("if_stall_done", {31'd0, if_stall}, 32'd0);
      chk("if_rdata_thru", if_rdata, rd);
      chk("d_ack_fetch", {31'd0, d_ack}, 32'd0);
    end else begin
      chk("d_ack_pulse", {31'd0, d_ack}, 32'd1);
      chk("if_stall_data", {31'd0, if_stall}, {31'd0, if_ce});
      if (!e.we) chk("d_rdata_thru", d_rdata, rd);
    end
    step();
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    if (!keep_d)  d_req = 1'b0;
    if (!keep_if) if_ce = 1'b0;
    #1;
    chk("mem_req_low", {31'd0, mem_req}, 32'd0);
    chk("d_ack_low", {31'd0, d_ack}, 32'd0);
    if (e.fetch)     chk("if_rdata_reg", if_rdata, rd);
    else if (!e.we)  chk("d_rdata_reg", d_rdata, rd);
  endtask

  initial begin
    rst = 1'b1; if_ce = 1'b1; if_addr = 32'h100;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_rdata = '0; mem_ready = 1'b0;

    // Reset with a pending fetch.
    step(); step();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_if_stall", {31'd0, if_stall}, 32'd1);
    chk("rst_d_ack", {31'd0, d_ack}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    rst = 1'b0;

    // Fetch granted on the first edge after release, latency 2.
    push_f(32'h100);
    serve(1, 2, 32'h0000_0013, 1'b0, 1'b0);

    // Store, latency 1.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    push_d(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011);
    serve(2, 1, 32'h0, 1'b0, 1'b0);

    // Contention: fetch gets every fifth grant. Loads present nonzero strobes,
    // which must not reach the memory.
    if_ce = 1'b1; if_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_wstrb = 4'hF; d_wdata = 32'h1234_5678;
    for (int k = 0; k < 11; k++) begin
      if (k == 4 || k == 9) push_f(32'h400);
      else                  push_d(1'b0, 32'h3000, 32'h0, 4'b0000);
    end
    for (int k = 0; k < 11; k++)
      serve(2, 1 + (k % 2), 32'hA000_0000 + k, k != 10, k != 10);

    // Simultaneous first request: data first, then fetch after the IDLE gap.
    if_ce = 1'b1; if_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3100;
    push_d(1'b0, 32'h3100, 32'h0, 4'b0000);
    push_f(32'h500);
    serve(1, 2, 32'h0BAD_F00D, 1'b0, 1'b1);
    serve(2, 1, 32'h0050_0093, 1'b0, 1'b0);

    // Build starve_cnt up to its limit, then reset during the fourth data access.
    if_ce = 1'b1; if_addr = 32'h600;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3200;
    for (int k = 0; k < 3; k++) push_d(1'b0, 32'h3200, 32'h0, 4'b0000);
    for (int k = 0; k < 3; k++) serve(2, 1, 32'hC000_0000 + k, 1'b1, 1'b1);
    step();
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    chk("pre_rst_addr", mem_addr, 32'h3200);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_d_ack", {31'd0, d_ack}, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_if_stall", {31'd0, if_stall}, 32'd1);
    step();
    chk("mid_rst_req_held", {31'd0, mem_req}, 32'd0);
    rst = 1'b0;
    // A cleared starve_cnt lets data win again. Had it survived at its limit,
    // fetch would be granted here.
    push_d(1'b0, 32'h3200, 32'h0, 4'b0000);
    push_f(32'h600);
    serve(1, 1, 32'hC0DE_0001, 1'b0, 1'b1);
    serve(2, 2, 32'h0060_0013, 1'b0, 1'b0);

    step();
    chk("final_idle_req", {31'd0, mem_req}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
